crc_engine: RTL and testbench
=============================

CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 Parameter DATA_W, default 8: input word width in bits; multiple of BPC.
REQ-002 Parameter CRC_W, default 16: CRC register width, 8..32.
REQ-003 Parameter BPC, default 1: bits processed per clock; divides DATA_W.
REQ-004 Parameter POLY, default 16'h1021: generator polynomial with the implicit top bit omitted.
REQ-005 Parameter INIT, default all-ones: CRC register value at frame start.
REQ-006 Parameter XOR_OUT, default 0: value XORed into the final CRC.
REQ-007 Parameter REFLECT_IN, default 0: 1 = feed each word LSB-first, 0 = MSB-first.
REQ-008 Parameter REFLECT_OUT, default 0: 1 = bit-reverse the CRC before XOR_OUT.
REQ-009 clk_i  in  1  single clock; all logic is on the rising edge.
REQ-010 rst_i  in  1  reset; synchronous, active-low.
REQ-011 clear_i  in  1  synchronous frame abort; has priority over all inputs except rst_i.
REQ-012 in_valid_i  in  1  in_data_i and in_last_i are valid.
REQ-013 in_ready_o  out  1  engine can accept a word.
REQ-014 in_data_i  in  DATA_W  message word.
REQ-015 in_last_i  in  1  word is the last of the frame.
REQ-016 crc_o  out  CRC_W  final CRC; valid while crc_valid_o is high.
REQ-017 crc_valid_o  out  1  crc_o is valid.
REQ-018 crc_ready_i  in  1  consumer accepts crc_o.

Function
REQ-019 State machine: IDLE, SHIFT, HOLD.
REQ-020 Word acceptance: a word is accepted when in_valid_i and in_ready_o are both high; in_ready_o is high only in IDLE.
REQ-021 Accept transition: IDLE -> SHIFT; capture the word and in_last_i; load the step counter with DATA_W/BPC.
REQ-022 SHIFT step: each cycle advance the CRC register by BPC bits (standard direct, non-augmented LFSR: feedback = CRC MSB XOR next data bit); decrement the counter.
REQ-023 End of word, not last: counter reaches zero with captured last = 0 -> IDLE, CRC register retained.
REQ-024 End of word, last: counter reaches zero with captured last = 1 -> HOLD.
REQ-025 Final CRC: on entering HOLD, crc_o = (REFLECT_OUT ? reverse(crc) : crc) XOR XOR_OUT, registered.
REQ-026 Word latency: an accepted word occupies exactly DATA_W/BPC cycles in SHIFT.
REQ-027 Output latency: crc_valid_o rises on the cycle after the last SHIFT cycle.
REQ-028 HOLD: crc_o and crc_valid_o are held stable until crc_ready_i is high.
REQ-029 HOLD exit: on the cycle crc_ready_i is high, go to IDLE, clear crc_valid_o and reload the CRC register with INIT.
REQ-030 No input in HOLD: in_ready_o stays low, so no word of the next frame is accepted before the CRC handshake completes.
REQ-031 clear_i in any state: go to IDLE, CRC register = INIT, crc_valid_o = 0, crc_o = 0, any pending word discarded.
REQ-032 clear_i with in_valid_i high in the same cycle: the word is not accepted.
REQ-033 A single-word frame (in_last_i = 1 on the first word) is legal.
REQ-034 Back-to-back words: at most one word per DATA_W/BPC + 1 cycles; in_ready_o deasserts for the whole SHIFT period.
REQ-035 Arithmetic: all CRC arithmetic is modulo CRC_W bits; POLY, INIT and XOR_OUT are truncated to CRC_W.

Reset
REQ-036 While rst_i = 0 at a clock edge: state = IDLE, CRC register = INIT, counter = 0, crc_o = 0, crc_valid_o = 0.
REQ-037 in_ready_o reads 0 during reset and 1 on the first cycle after rst_i returns high.
REQ-038 Reset mid-frame or in HOLD discards all progress; no CRC is emitted.

Structure
REQ-039 Package crc_pkg holds the state enum typedef and the standard polynomial constants: CRC16_CCITT 16'h1021, CRC32 32'h04C11DB7, CRC8 8'h07.
REQ-040 Sub-module crc_step is purely combinational: one BPC-bit LFSR advance from (crc, data bits, POLY).
REQ-041 crc_engine instantiates crc_step once; all state stays in crc_engine.

Verification
REQ-042 CRC16_CCITT, INIT FFFF, DATA_W 8, BPC 1: bytes "123456789", last on '9' -> crc_o = 16'h29B1.
REQ-043 Same stimulus with INIT 0000 -> crc_o = 16'h31C3; repeat with BPC 8 -> same value, each word taking 1 SHIFT cycle.
REQ-044 CRC_W 32, POLY CRC32, INIT/XOR_OUT FFFFFFFF, REFLECT_IN/OUT 1: "123456789" -> crc_o = 32'hCBF43926.
REQ-045 Hold CRC output: crc_ready_i held low for 5 cycles after crc_valid_o -> crc_o stable, in_ready_o = 0; release -> IDLE next cycle, next frame result is independent.
REQ-046 clear_i pulsed after byte "1234", then "123456789" sent (CCITT, INIT FFFF) -> 16'h29B1.
REQ-047 rst_i low during HOLD -> crc_valid_o = 0 next cycle and no CRC is emitted for that frame.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: FSM state type and standard generator polynomials shared by the CRC engine and its users
package crc_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32 = 32'h04C11DB7;
  localparam logic [7:0] CRC8 = 8'h07;
endpackage

// File: rtl/crc_step.sv
// crc_step: combinational BPC-bit direct (non-augmented) LFSR advance; ports: crc in, bits in (bits[BPC-1] consumed first), crc_next out
module crc_step #(
  parameter int CRC_W = 16,
  parameter int BPC = 1,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(16'h1021)
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [BPC-1:0]   bits,
  output logic [CRC_W-1:0] crc_next
);
  always_comb begin
    crc_next = crc;
    for (int i = BPC - 1; i >= 0; i--)
      crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ ((crc_next[CRC_W-1] ^ bits[i]) ? POLY : '0);
  end
endmodule

// File: rtl/crc_engine.sv
// crc_engine: word-serial CRC generator, BPC bits per clock
//   clk_i/rst_i (sync, active-low), clear_i frame abort,
//   in_valid_i/in_ready_o/in_data_i/in_last_i word input,
//   crc_o/crc_valid_o/crc_ready_i final CRC handshake
module crc_engine
  import crc_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          CRC_W       = 16,
  parameter int          BPC         = 1,
  parameter logic [31:0] POLY        = 32'h0000_1021,
  parameter logic [31:0] INIT        = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT     = 32'h0,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic [CRC_W-1:0]  crc_o,
  output logic              crc_valid_o,
  input  logic              crc_ready_i
);
  localparam int STEPS = DATA_W / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
  localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
  state_t state, state_d;
  logic [CRC_W-1:0] crc, crc_nxt, crc_fin;
  logic [DATA_W-1:0] word, word_in;
  logic [CNT_W-1:0] cnt;
  logic last, accept, done;
  assign in_ready_o = rst_i && state == IDLE;
  assign accept = in_ready_o && in_valid_i && !clear_i;
  assign done = state == SHIFT && cnt == CNT_W'(1);
  // words are stored pre-reflected so the shifter always consumes the MSB first
  always_comb begin
    word_in = in_data_i;
    crc_fin = crc_nxt;
    for (int i = 0; i < DATA_W; i++) word_in[i] = REFLECT_IN ? in_data_i[DATA_W-1-i] : in_data_i[i];
    for (int i = 0; i < CRC_W; i++) crc_fin[i] = REFLECT_OUT ? crc_nxt[CRC_W-1-i] : crc_nxt[i];
    crc_fin = crc_fin ^ XOR_OUT[CRC_W-1:0];
  end
  crc_step #(.CRC_W(CRC_W), .BPC(BPC), .POLY(POLY[CRC_W-1:0])) u_step (
    .crc(crc),
    .bits(word[DATA_W-1 -: BPC]),
    .crc_next(crc_nxt)
  );
  always_ff @(posedge clk_i) state <= !rst_i ? IDLE : state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = accept ? SHIFT : IDLE;
      SHIFT:   state_d = done ? (last ? HOLD : IDLE) : SHIFT;
      HOLD:    state_d = crc_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      crc <= INIT_C;
      cnt <= '0;
      word <= '0;
      last <= 1'b0;
      crc_o <= '0;
      crc_valid_o <= 1'b0;
    end else begin
      if (accept) begin
        word <= word_in;
        last <= in_last_i;
        cnt <= STEPS_C;
      end
      if (state == SHIFT) begin
        crc <= crc_nxt;
        word <= word << BPC;
        cnt <= cnt - CNT_W'(1);
        if (done && last) begin
          crc_o <= crc_fin;
          crc_valid_o <= 1'b1;
        end
      end
      if (state == HOLD && crc_ready_i) begin
        crc <= INIT_C;
        crc_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: four engine configurations checked against a long-division CRC model
module tb_crc_engine;
  import crc_pkg::*;
  typedef logic [7:0] bq_t [$];
  localparam int          CW  [4] = '{16, 16, 16, 32};
  localparam logic [31:0] POL [4] = '{32'h1021, 32'h1021, 32'h1021, 32'h04C11DB7};
  localparam logic [31:0] INI [4] = '{32'hFFFF, 32'h0, 32'h0, 32'hFFFFFFFF};
  localparam logic [31:0] XO  [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
  localparam bit          RF  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam int          STP [4] = '{8, 8, 1, 8};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic in_valid [4], in_last [4], clear [4], crc_ready [4], rdy [4], vld [4];
  logic [7:0] data [4];
  logic [15:0] c16 [3];
  logic [31:0] c32;
  int total = 0, bad = 0;
  crc_engine #(.POLY({16'h0, CRC16_CCITT})) u0 (
    .clk_i(clk), .rst_i(rst_n), .clear_i(clear[0]), .in_valid_i(in_valid[0]), .in_ready_o(rdy[0]),
    .in_data_i(data[0]), .in_last_i(in_last[0]), .crc_o(c16[0]), .crc_valid_o(vld[0]), .crc_ready_i(crc_ready[0]));
  crc_engine #(.POLY({16'h0, CRC16_CCITT}), .INIT(32'h0)) u1 (
    .clk_i(clk), .rst_i(rst_n), .clear_i(clear[1]), .in_valid_i(in_valid[1]), .in_ready_o(rdy[1]),
    .in_data_i(data[1]), .in_last_i(in_last[1]), .crc_o(c16[1]), .crc_valid_o(vld[1]), .crc_ready_i(crc_ready[1]));
  crc_engine #(.POLY({16'h0, CRC16_CCITT}), .INIT(32'h0), .BPC(8)) u2 (
    .clk_i(clk), .rst_i(rst_n), .clear_i(clear[2]), .in_valid_i(in_valid[2]), .in_ready_o(rdy[2]),
    .in_data_i(data[2]), .in_last_i(in_last[2]), .crc_o(c16[2]), .crc_valid_o(vld[2]), .crc_ready_i(crc_ready[2]));
  crc_engine #(.CRC_W(32), .POLY(CRC32), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
               .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u3 (
    .clk_i(clk), .rst_i(rst_n), .clear_i(clear[3]), .in_valid_i(in_valid[3]), .in_ready_o(rdy[3]),
    .in_data_i(data[3]), .in_last_i(in_last[3]), .crc_o(c32), .crc_valid_o(vld[3]), .crc_ready_i(crc_ready[3]));

  function automatic logic [31:0] rd_crc(input int k);
    if (k == 3) return c32;
    return {16'h0, c16[k]};
  endfunction

  function automatic logic [31:0] b32(input logic b);
    return {31'b0, b};
  endfunction

  // CRC as the remainder of the augmented message (init folded into its leading bits) divided by the full polynomial
  function automatic logic [31:0] model(input int k, input bq_t msg);
    int w;
    bit b [$];
    bit pb [33];
    logic [31:0] r, o;
    w = CW[k];
    r = '0;
    o = '0;
    for (int j = 0; j <= w; j++) pb[j] = (j == 0) ? 1'b1 : POL[k][w-j];
    foreach (msg[i]) for (int j = 0; j < 8; j++) b.push_back(RF[k] ? msg[i][j] : msg[i][7-j]);
    for (int j = 0; j < w; j++) b.push_back(1'b0);
    for (int j = 0; j < w; j++) b[j] = b[j] ^ INI[k][w-1-j];
    for (int i = 0; i + w < b.size(); i++)
      if (b[i]) for (int j = 0; j <= w; j++) b[i+j] = b[i+j] ^ pb[j];
    for (int j = 0; j < w; j++) r[w-1-j] = b[b.size()-w+j];
    for (int j = 0; j < w; j++) o[j] = RF[k] ? r[w-1-j] : r[j];
    return o ^ XO[k];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic send_word(input int k, input logic [7:0] d, input bit l);
    int t = 0;
    while (!rdy[k] && t < 50) begin @(negedge clk); t++; end
    check($sformatf("ready_wait%0d", k), b32(rdy[k]), 32'd1);
    in_valid[k] = 1'b1;
    data[k] = d;
    in_last[k] = l;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_last[k] = 1'b0;
    t = 0;
    while (!(l ? vld[k] : rdy[k]) && t < 50) begin @(negedge clk); t++; end
    check($sformatf("latency%0d", k), t, STP[k]);
  endtask

  task automatic finish_frame(input int k, input logic [31:0] exp, input int hold);
    check($sformatf("crc%0d", k), rd_crc(k), exp);
    check($sformatf("valid%0d", k), b32(vld[k]), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("hold_crc%0d", k), rd_crc(k), exp);
      check($sformatf("hold_valid%0d", k), b32(vld[k]), 32'd1);
      check($sformatf("hold_ready%0d", k), b32(rdy[k]), 32'd0);
    end
    crc_ready[k] = 1'b1;
    @(negedge clk);
    crc_ready[k] = 1'b0;
    check($sformatf("exit_valid%0d", k), b32(vld[k]), 32'd0);
    check($sformatf("exit_ready%0d", k), b32(rdy[k]), 32'd1);
  endtask

  task automatic send_frame(input int k, input bq_t msg, input int hold, input logic [31:0] exp);
    for (int i = 0; i < msg.size(); i++) send_word(k, msg[i], i == msg.size() - 1);
    finish_frame(k, exp, hold);
  endtask

  task automatic pulse_clear(input int k);
    clear[k] = 1'b1;
    @(negedge clk);
    clear[k] = 1'b0;
    check("clear_ready", b32(rdy[k]), 32'd1);
    check("clear_valid", b32(vld[k]), 32'd0);
    check("clear_crc", rd_crc(k), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s9, m;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; in_last[k] = 1'b0; clear[k] = 1'b0; crc_ready[k] = 1'b0; data[k] = 8'h0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_ready", b32(rdy[k]), 32'd0);
      check("rst_valid", b32(vld[k]), 32'd0);
      check("rst_crc", rd_crc(k), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("post_rst_ready", b32(rdy[k]), 32'd1);
    for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));
    send_frame(0, s9, 0, 32'h29B1);
    send_frame(1, s9, 0, 32'h31C3);
    send_frame(2, s9, 0, 32'h31C3);
    send_frame(3, s9, 0, 32'hCBF43926);
    send_frame(0, s9, 5, 32'h29B1);
    m = '{8'hA5};
    send_frame(0, m, 1, model(0, m));
    for (int i = 0; i < 4; i++) send_word(0, 8'h31 + 8'(i), 1'b0);
    pulse_clear(0);
    send_frame(0, s9, 0, 32'h29B1);
    clear[0] = 1'b1; in_valid[0] = 1'b1; data[0] = 8'h55; in_last[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0; in_valid[0] = 1'b0; in_last[0] = 1'b0;
    check("clear_with_valid_ready", b32(rdy[0]), 32'd1);
    check("clear_with_valid_valid", b32(vld[0]), 32'd0);
    send_frame(0, s9, 0, 32'h29B1);
    send_word(0, 8'h31, 1'b0);
    in_valid[0] = 1'b1; data[0] = 8'h32;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("shift_ready_low", b32(rdy[0]), 32'd0);
    pulse_clear(0);
    send_frame(0, s9, 0, 32'h29B1);
    for (int i = 0; i < 9; i++) send_word(0, s9[i], i == 8);
    check("hold_before_clear", rd_crc(0), 32'h29B1);
    pulse_clear(0);
    for (int i = 0; i < 9; i++) send_word(0, s9[i], i == 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("hold_rst_valid", b32(vld[0]), 32'd0);
    check("hold_rst_crc", rd_crc(0), 32'd0);
    check("hold_rst_ready", b32(rdy[0]), 32'd0);
    rst_n = 1'b1;
    crc_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    crc_ready[0] = 1'b0;
    check("hold_rst_no_emit", b32(vld[0]), 32'd0);
    send_frame(0, s9, 0, 32'h29B1);
    for (int k = 0; k < 4; k++)
      for (int f = 0; f < 6; f++) begin
        m.delete();
        for (int i = 0; i < int'($urandom_range(1, 6)); i++) m.push_back(8'($urandom));
        send_frame(k, m, int'($urandom_range(0, 3)), model(k, m));
      end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
